// File: rtl/scroll_pkg.sv
// Shared types and constants for the seven-segment scroll sequencer.
package scroll_pkg;

  typedef logic [2:0] char_t;

  localparam char_t CHAR_H     = 3'd0;
  localparam char_t CHAR_E     = 3'd1;
  localparam char_t CHAR_L     = 3'd2;
  localparam char_t CHAR_O     = 3'd3;
  localparam char_t CHAR_BLANK = 3'd7;

  localparam char_t MESSAGE [8] = '{CHAR_H, CHAR_E, CHAR_L, CHAR_L,
                                    CHAR_O, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK};

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/scroll_controller_if.sv
// Control inputs and chain-side outputs of the scroll sequencer.
interface scroll_controller_if;
  import scroll_pkg::*;

  logic  run;
  logic  step;
  logic  clear;
  char_t char_out;
  logic  shift_en;
  logic  msg_wrap;
  logic  busy;

  modport master (output run, step, clear,
                  input  char_out, shift_en, msg_wrap, busy);

  modport slave  (input  run, step, clear,
                  output char_out, shift_en, msg_wrap, busy);
endinterface

// File: rtl/scroll_controller_tick_prescaler.sv
// Free-running step-rate divider; tick is high in the last count of each period.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PC_W = $clog2(TICK_DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

  logic [PC_W-1:0] pc_q, pc_d;

  assign tick = (pc_q == PC_LAST);

  always_comb begin
    pc_d = pc_q;
    if (clr)
      pc_d = '0;
    else if (en)
      pc_d = tick ? '0 : pc_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

endmodule

// File: rtl/scroll_controller.sv
// Scroll sequencer: feeds "HELLO   " into the 8-stage character chain.
//   state | meaning
//   FLUSH | push CHAIN_LEN blanks, one per tick
//   RUN   | push next message char each tick
//   PAUSE | shift only on step
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int CHAIN_LEN = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  scroll_controller_if.slave  bus
);

  localparam int FC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(CHAIN_LEN - 1);

  state_t          state_q;
  logic [FC_W-1:0] fc_q;
  logic [2:0]      idx_q;
  logic [2:0]      idx_d;
  char_t           char_out_q;
  logic            shift_en_q;
  logic            msg_wrap_q;
  logic            tick;
  logic            pc_clr;
  logic            pc_en;

  assign idx_d  = idx_q + 3'd1;
  assign pc_en  = (state_q != PAUSE);
  // Holding pc at zero while paused makes the RUN re-entry a full period.
  assign pc_clr = bus.clear || (state_q == PAUSE) || (state_q == RUN && !bus.run);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (pc_clr),
    .en     (pc_en),
    .tick   (tick)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= FLUSH;
      fc_q       <= '0;
      idx_q      <= '0;
      char_out_q <= CHAR_BLANK;
      shift_en_q <= 1'b0;
      msg_wrap_q <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      msg_wrap_q <= 1'b0;
      if (bus.clear) begin
        state_q <= FLUSH;
        fc_q    <= '0;
      end else begin
        case (state_q)
          FLUSH: begin
            if (tick) begin
              shift_en_q <= 1'b1;
              char_out_q <= CHAR_BLANK;
              if (fc_q == FC_LAST) begin
                fc_q    <= '0;
                idx_q   <= '0;
                state_q <= bus.run ? RUN : PAUSE;
              end else begin
                fc_q <= fc_q + 1'b1;
              end
            end
          end
          RUN: begin
            if (!bus.run) begin
              state_q <= PAUSE;
            end else if (tick) begin
              shift_en_q <= 1'b1;
              char_out_q <= MESSAGE[idx_q];
              msg_wrap_q <= (idx_q == 3'd7);
              idx_q      <= idx_d;
            end
          end
          PAUSE: begin
            if (bus.run) begin
              state_q <= RUN;
            end else if (bus.step) begin
              shift_en_q <= 1'b1;
              char_out_q <= MESSAGE[idx_q];
              msg_wrap_q <= (idx_q == 3'd7);
              idx_q      <= idx_d;
            end
          end
          default: state_q <= FLUSH;
        endcase
      end
    end
  end

  assign bus.char_out = char_out_q;
  assign bus.shift_en = shift_en_q;
  assign bus.msg_wrap = msg_wrap_q;
  assign bus.busy     = (state_q == FLUSH);

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with TICK_DIV=4, CHAIN_LEN=8.
module tb_scroll_controller;

  localparam int TD = 4;
  localparam int CL = 8;

  logic Clock;
  logic Resetn;
  int   n_vec;
  int   n_bad;

  scroll_controller_if bus ();

  scroll_controller #(.TICK_DIV(TD), .CHAIN_LEN(CL)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int ch, input int sh,
                               input int wrap, input int bsy);
    check_val({tag, "_char"},  int'(bus.char_out), ch);
    check_val({tag, "_shift"}, int'(bus.shift_en), sh);
    check_val({tag, "_wrap"},  int'(bus.msg_wrap), wrap);
    check_val({tag, "_busy"},  int'(bus.busy),     bsy);
  endtask

  // TD-1 quiet edges, then one shift carrying the given character.
  task automatic expect_shift(input string tag, input int ch, input int wrap, input int bsy);
    repeat (TD - 1) begin
      clk_edge();
      check_val({tag, "_idle"}, int'(bus.shift_en), 0);
    end
    clk_edge();
    check_outputs(tag, ch, 1, wrap, bsy);
  endtask

  task automatic blanks(input string tag, input int n, input bit ends_flush);
    for (int k = 0; k < n; k++)
      expect_shift($sformatf("%s_b%0d", tag, k), 7, 0,
                   (ends_flush && k == n - 1) ? 0 : 1);
  endtask

  task automatic async_reset(input string tag);
    Resetn = 1'b0;
    #2;
    check_outputs(tag, 7, 0, 0, 1);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  int run_chars [10] = '{0, 1, 2, 2, 3, 7, 7, 7, 0, 1};
  int step_chars [3] = '{2, 2, 3};

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    bus.run   = 1'b1;
    bus.step  = 1'b0;
    bus.clear = 1'b0;
    Resetn    = 1'b1;
    #1;
    Resetn = 1'b0;
    #2;
    check_outputs("rst", 7, 0, 0, 1);
    @(negedge Clock);
    Resetn = 1'b1;

    blanks("flush", CL, 1'b1);

    for (int k = 0; k < 10; k++)
      expect_shift($sformatf("run%0d", k), run_chars[k], (k == 7) ? 1 : 0, 0);

    bus.run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk_edge();
      check_outputs($sformatf("pause%0d", k), 1, 0, 0, 0);
    end

    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      clk_edge();
      check_outputs($sformatf("step%0d", k), step_chars[k], 1, 0, 0);
      bus.step = 1'b0;
      clk_edge();
      check_val($sformatf("step%0d_after", k), int'(bus.shift_en), 0);
    end

    bus.run  = 1'b1;
    bus.step = 1'b1;
    clk_edge();
    check_val("resume_step_ignored", int'(bus.shift_en), 0);
    clk_edge();
    check_val("run_step_ignored", int'(bus.shift_en), 0);
    bus.step = 1'b0;
    repeat (TD - 2) begin
      clk_edge();
      check_val("resume_idle", int'(bus.shift_en), 0);
    end
    clk_edge();
    check_outputs("resume", 7, 1, 0, 0);

    bus.run = 1'b0;
    clk_edge();
    check_val("to_pause", int'(bus.shift_en), 0);
    bus.run   = 1'b1;
    bus.clear = 1'b1;
    bus.step  = 1'b1;
    clk_edge();
    check_val("clr_shift", int'(bus.shift_en), 0);
    check_val("clr_busy",  int'(bus.busy), 1);
    bus.clear = 1'b0;
    bus.step  = 1'b0;
    blanks("clrfl", CL, 1'b1);
    expect_shift("clr_h", 0, 0, 0);

    async_reset("arst");
    blanks("refl", CL, 1'b1);
    expect_shift("re_h", 0, 0, 0);

    async_reset("arst2");
    blanks("pre", 5, 1'b0);
    bus.clear = 1'b1;
    clk_edge();
    check_val("fclr_shift", int'(bus.shift_en), 0);
    check_val("fclr_busy",  int'(bus.busy), 1);
    bus.clear = 1'b0;
    blanks("post", CL, 1'b1);
    expect_shift("post_h", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
